// File: rtl/dm_arbiter.sv
// Data-memory arbiter: CPU MEM stage (port c) vs DMA/debug loader (port d) with
// starvation promotion and bounded burst locking. Statistics counters: DM_ARB_STATS_EN.
module dm_arbiter #(
   parameter int ADDR_W   = 7,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4,
   parameter int MAX_LOCK = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              c_req,
   input  logic              c_wr,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_gnt,
   output logic              c_stall,
   output logic [DATA_W-1:0] c_rdata,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic              d_lock,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] dm_addr,
   output logic              dm_rd,
   output logic              dm_wr,
   output logic [DATA_W-1:0] dm_wdata,
   input  logic [DATA_W-1:0] dm_rdata,
   output logic [15:0]       stat_conflicts,
   output logic [15:0]       stat_promotions
);

   // state | meaning
   // NORMAL | CPU has priority; DMA wins only when promoted
   // LOCKED | DMA owns the memory for a burst
   localparam logic [0:0] ST_NORMAL = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
   localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

   logic [0:0] state_q, state_d;
   logic [3:0] wcnt_q, wcnt_d;
   logic [7:0] lcnt_q, lcnt_d;
   logic       force_q, force_d;
   logic       promote, lock_full;

   assign promote   = (wcnt_q >= MAX_WAIT_C);
   assign lock_full = (lcnt_q == MAX_LOCK_C);

   always_comb begin
      c_gnt = 1'b0;
      d_gnt = 1'b0;
      if (!reset) begin
         if (state_q == ST_LOCKED) begin
            d_gnt = d_req & d_lock & ~(lock_full & c_req);
         end else if (!force_q && promote && d_req) begin
            d_gnt = 1'b1;
         end else begin
            c_gnt = c_req;
            d_gnt = d_req & ~c_req;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      lcnt_d  = lcnt_q;
      force_d = 1'b0;
      if (state_q == ST_LOCKED) begin
         if (d_gnt) begin
            lcnt_d = lock_full ? lcnt_q : lcnt_q + 8'd1;
         end else begin
            state_d = ST_NORMAL;
            lcnt_d  = 8'd0;
            // Still wanting the lock here means the burst hit its limit with the CPU waiting
            force_d = d_req & d_lock;
         end
      end else if (d_gnt && d_lock && !force_q) begin
         state_d = ST_LOCKED;
         lcnt_d  = 8'd1;
      end
      if (d_req && !d_gnt) wcnt_d = (wcnt_q == 4'hF) ? wcnt_q : wcnt_q + 4'd1;
      else                 wcnt_d = 4'd0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_NORMAL;
         wcnt_q  <= 4'd0;
         lcnt_q  <= 8'd0;
         force_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         lcnt_q  <= lcnt_d;
         force_q <= force_d;
      end
   end

   assign c_stall  = c_req & ~c_gnt;
   assign dm_wr    = (c_gnt & c_wr) | (d_gnt & d_wr);
   assign dm_rd    = (c_gnt & ~c_wr) | (d_gnt & ~d_wr);
   assign dm_addr  = d_gnt ? d_addr  : (c_gnt ? c_addr  : '0);
   assign dm_wdata = d_gnt ? d_wdata : (c_gnt ? c_wdata : '0);
   assign c_rdata  = dm_rdata;
   assign d_rdata  = dm_rdata;

`ifdef DM_ARB_STATS_EN
   logic [15:0] conf_q, prom_q;
   logic        promo_win;

   assign promo_win = ~reset & (state_q == ST_NORMAL) & ~force_q & promote & d_req;

   always_ff @(posedge clk) begin
      if (reset) begin
         conf_q <= 16'd0;
         prom_q <= 16'd0;
      end else begin
         if (c_req && d_req && conf_q != 16'hFFFF) conf_q <= conf_q + 16'd1;
         if (promo_win && prom_q != 16'hFFFF)      prom_q <= prom_q + 16'd1;
      end
   end

   assign stat_conflicts  = conf_q;
   assign stat_promotions = prom_q;
`else
   assign stat_conflicts  = 16'd0;
   assign stat_promotions = 16'd0;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: ownership model checked every cycle plus directed literal cases.
module tb_dm_arbiter;
   localparam int ADDR_W   = 7;
   localparam int DATA_W   = 32;
   localparam int MAX_WAIT = 4;
   localparam int MAX_LOCK = 8;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              c_req = 1'b0, c_wr = 1'b0;
   logic [ADDR_W-1:0] c_addr = '0;
   logic [DATA_W-1:0] c_wdata = '0;
   logic              d_req = 1'b0, d_wr = 1'b0, d_lock = 1'b0;
   logic [ADDR_W-1:0] d_addr = '0;
   logic [DATA_W-1:0] d_wdata = '0;
   logic              c_gnt, c_stall, d_gnt, dm_rd, dm_wr;
   logic [DATA_W-1:0] c_rdata, d_rdata, dm_wdata, dm_rdata;
   logic [ADDR_W-1:0] dm_addr;
   logic [15:0]       stat_conflicts, stat_promotions;

   dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .MAX_LOCK(MAX_LOCK)) dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_stall(c_stall), .c_rdata(c_rdata),
      .d_req(d_req), .d_wr(d_wr), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rdata(d_rdata),
      .dm_addr(dm_addr), .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
      .stat_conflicts(stat_conflicts), .stat_promotions(stat_promotions)
   );

   always #5 clk = ~clk;

   // Memory instance: combinational read, write-through
   logic [DATA_W-1:0] mem [128] = '{default: '0};
   assign dm_rdata = dm_wr ? dm_wdata : mem[dm_addr];
   always @(posedge clk) if (dm_wr) mem[dm_addr] <= dm_wdata;

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference model: who owns the memory, expressed as run lengths and flags
   logic [DATA_W-1:0] ref_mem [128] = '{default: '0};
   bit  m_locked = 0, m_owed = 0, e_promoted, e_wr;
   int  m_denied = 0, m_burst = 0, m_conf = 0, m_prom = 0;
   int  owner;                        // 0 nobody, 1 CPU, 2 DMA
   logic [ADDR_W-1:0] e_addr;
   logic [DATA_W-1:0] e_wdata;

   always @(negedge clk) begin
      e_promoted = 0;
      if (reset) owner = 0;
      else if (m_locked)
         owner = (d_req && d_lock && !(m_burst >= MAX_LOCK && c_req)) ? 2 : 0;
      else begin
         e_promoted = !m_owed && (m_denied >= MAX_WAIT);
         owner = (d_req && e_promoted) ? 2 : (c_req ? 1 : (d_req ? 2 : 0));
      end
      e_wr    = (owner == 2) ? d_wr    : ((owner == 1) ? c_wr    : 1'b0);
      e_addr  = (owner == 2) ? d_addr  : ((owner == 1) ? c_addr  : '0);
      e_wdata = (owner == 2) ? d_wdata : ((owner == 1) ? c_wdata : '0);

      chk("c_gnt",   32'(c_gnt),   32'(owner == 1));
      chk("d_gnt",   32'(d_gnt),   32'(owner == 2));
      chk("c_stall", 32'(c_stall), 32'(c_req && owner != 1));
      chk("dm_wr",   32'(dm_wr),   32'(owner != 0 && e_wr));
      chk("dm_rd",   32'(dm_rd),   32'(owner != 0 && !e_wr));
      chk("dm_addr", 32'(dm_addr), 32'(e_addr));
      chk("dm_wdata", dm_wdata, e_wdata);
      if (owner != 0 && !e_wr) begin
         chk("c_rdata", c_rdata, ref_mem[e_addr]);
         chk("d_rdata", d_rdata, ref_mem[e_addr]);
      end
`ifdef DM_ARB_STATS_EN
      chk("stat_conflicts",  32'(stat_conflicts),  m_conf);
      chk("stat_promotions", 32'(stat_promotions), m_prom);
`else
      chk("stat_conflicts",  32'(stat_conflicts),  0);
      chk("stat_promotions", 32'(stat_promotions), 0);
`endif

      if (owner != 0 && e_wr) ref_mem[e_addr] = e_wdata;
      if (reset) begin
         m_locked = 0; m_owed = 0; m_denied = 0; m_burst = 0; m_conf = 0; m_prom = 0;
      end else begin
         if (c_req && d_req && m_conf < 65535) m_conf++;
         if (e_promoted && d_req && m_prom < 65535) m_prom++;
         if (m_locked) begin
            if (owner == 2) m_burst = (m_burst < MAX_LOCK) ? m_burst + 1 : MAX_LOCK;
            else begin
               m_owed   = d_req && d_lock;
               m_locked = 0;
               m_burst  = 0;
            end
         end else begin
            if (owner == 2 && d_lock && !m_owed) begin
               m_locked = 1;
               m_burst  = 1;
            end
            m_owed = 0;
         end
         m_denied = (d_req && owner != 2) ? m_denied + 1 : 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic idle();
      c_req = 0; c_wr = 0; c_addr = '0; c_wdata = '0;
      d_req = 0; d_wr = 0; d_lock = 0; d_addr = '0; d_wdata = '0;
   endtask

   task automatic reset_pulse();
      idle();
      reset = 1;
      tick();
      reset = 0;
   endtask

   logic [11:0] dv, cv, sv;

   initial begin
      // Reset-asserted cycle with a CPU request pending
      reset = 1; c_req = 1;
      tick(); settle();
      chk("rst_c_gnt",   32'(c_gnt),   0);
      chk("rst_c_stall", 32'(c_stall), 1);
      chk("rst_d_gnt",   32'(d_gnt),   0);
      tick();
      reset = 0;

      // CPU-only write then read back
      c_req = 1; c_wr = 1; c_addr = 7'h05; c_wdata = 32'hDEADBEEF;
      settle();
      chk("cpu_wr_gnt",   32'(c_gnt),   1);
      chk("cpu_wr_stall", 32'(c_stall), 0);
      chk("cpu_wr_dmwr",  32'(dm_wr),   1);
      tick();
      c_wr = 0;
      settle();
      chk("cpu_rd_gnt",  32'(c_gnt), 1);
      chk("cpu_rd_data", c_rdata,    32'hDEADBEEF);
      tick();

      // Continuous contention, no lock: DMA promoted every fifth cycle
      reset_pulse();
      c_req = 1; d_req = 1;
      dv = '0; sv = '0;
      for (int i = 0; i < 10; i++) begin
         settle();
         dv[i] = d_gnt; sv[i] = c_stall;
`ifdef DM_ARB_STATS_EN
         if (i == 5) chk("prom_after_4", 32'(stat_promotions), 1);
`else
         if (i == 5) chk("prom_after_4", 32'(stat_promotions), 0);
`endif
         tick();
      end
      chk("contend_dgnt",  32'(dv), 32'h210);
      chk("contend_stall", 32'(sv), 32'h210);

      // Locked burst with CPU waiting: 8 grants, one release cycle, CPU next
      reset_pulse();
      d_req = 1; d_lock = 1; d_wr = 1;
      dv = '0; cv = '0; sv = '0;
      for (int i = 0; i < 10; i++) begin
         c_req = (i > 0);
         d_addr = 7'(16 + ((i < 8) ? i : 7));
         d_wdata = 32'hA000_0000 + 32'(i);
         settle();
         dv[i] = d_gnt; cv[i] = c_gnt; sv[i] = c_stall;
         tick();
      end
      chk("burst_dgnt",  32'(dv), 32'h0FF);
      chk("burst_cgnt",  32'(cv), 32'h200);
      chk("burst_stall", 32'(sv), 32'h1FE);

      // Locked burst with no CPU: lock continues past MAX_LOCK
      reset_pulse();
      d_req = 1; d_lock = 1; d_wr = 0;
      dv = '0;
      for (int i = 0; i < 12; i++) begin
         d_addr = 7'(i);
         settle();
         dv[i] = d_gnt;
         tick();
      end
      chk("sat_dgnt", 32'(dv), 32'hFFF);
      c_req = 1;
      settle();
      chk("sat_release_dgnt", 32'(d_gnt), 0);
      tick();
      settle();
      chk("sat_forced_cgnt", 32'(c_gnt), 1);
      tick();

      // Reset on the third cycle of a locked burst
      reset_pulse();
      d_req = 1; d_lock = 1; d_wr = 1; d_addr = 7'h30; d_wdata = 32'h1234_5678;
      tick(); tick();
      reset = 1;
      settle();
      chk("rst_burst_dgnt", 32'(d_gnt), 0);
      chk("rst_burst_dmwr", 32'(dm_wr), 0);
      tick();
      reset = 0; c_req = 1; c_wr = 0; c_addr = 7'h05;
      settle();
      chk("rst_burst_cgnt", 32'(c_gnt), 1);
      chk("rst_burst_dgnt2", 32'(d_gnt), 0);
      tick();

      // Randomized traffic, alternating lock-heavy and mixed phases
      idle();
      for (int i = 0; i < 3000; i++) begin
         reset  = ($urandom_range(127) == 0);
         c_req  = ($urandom_range(1) == 1);
         c_wr   = ($urandom_range(1) == 1);
         c_addr = 7'($urandom_range(127));
         c_wdata = $urandom;
         if ((i / 300) % 2 == 0) begin
            d_req  = ($urandom_range(19) != 0);
            d_lock = ($urandom_range(19) != 0);
         end else begin
            d_req  = ($urandom_range(9) < 7);
            d_lock = ($urandom_range(1) == 1);
         end
         d_wr   = ($urandom_range(1) == 1);
         d_addr = 7'($urandom_range(127));
         d_wdata = $urandom;
         tick();
      end

      // Long conflict run saturates the conflict counter
      reset_pulse();
      c_req = 1; d_req = 1; d_lock = 0;
      for (int i = 0; i < 65600; i++) tick();
      settle();
`ifdef DM_ARB_STATS_EN
      chk("conf_saturated", 32'(stat_conflicts), 32'hFFFF);
`else
      chk("conf_saturated", 32'(stat_conflicts), 0);
`endif
      tick();
      idle();
      tick();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
